// File: rtl/adc_therm_pkg.sv
// Shared constants and helpers for the thermometer encode/decode blocks.
// Element count and modular pointer arithmetic for the 15-element sub-DAC.
package adc_therm_pkg;

  localparam int unsigned NBITS = 4;
  localparam int unsigned NELEM = (2 ** NBITS) - 1;
  localparam int unsigned SUMW  = NBITS + 1;

  // (ptr + b) mod NELEM; valid because ptr < NELEM and b <= NELEM, so one subtract suffices
  function automatic logic [NBITS-1:0] mod_add_nelem(input logic [NBITS-1:0] ptr,
                                                     input logic [NBITS-1:0] b);
    logic [SUMW-1:0] sum;
    sum = SUMW'(ptr) + SUMW'(b);
    if (sum >= SUMW'(NELEM)) begin
      sum = sum - SUMW'(NELEM);
    end
    return sum[NBITS-1:0];
  endfunction

endpackage

// File: rtl/therm_rotate.sv
// Combinational thermometer mask generator with circular rotation by ptr.
// Produces b consecutive ones starting at element ptr, wrapping within NELEM bits.
module therm_rotate
  import adc_therm_pkg::*;
(
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] ptr,
  output logic [NELEM-1:0] y_c
);

  logic [NELEM:0]     one_hot_c;
  logic [NELEM-1:0]   mask_c;
  logic [2*NELEM-1:0] shifted_c;

  // Mask (1<<b)-1 computed one bit wider so b=15 yields all ones
  always_comb begin
    one_hot_c = (NELEM + 1)'(1) << b;
    mask_c    = NELEM'(one_hot_c - (NELEM + 1)'(1));
    shifted_c = {NELEM'(0), mask_c} << ptr;
    y_c       = shifted_c[NELEM-1:0] | shifted_c[2*NELEM-1:NELEM];
  end

endmodule

// File: rtl/bin2therm_dwa.sv
// Binary-to-thermometer decoder with optional data-weighted averaging.
// Registers the element-select word, its valid flag and the rotation pointer.
module bin2therm_dwa
  import adc_therm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] b,
  input  logic             b_valid,
  input  logic             dwa_en,
  output logic [NELEM-1:0] Y,
  output logic             Y_valid,
  output logic [NBITS-1:0] ptr
);

  logic [NBITS-1:0] rot_ptr_c;
  logic [NELEM-1:0] rot_y_c;
  logic [NBITS-1:0] ptr_next_c;

  // Plain mode decodes from element 0 even on the edge that leaves DWA
  always_comb begin
    rot_ptr_c  = dwa_en ? ptr : '0;
    ptr_next_c = ptr;
    if (!dwa_en) begin
      ptr_next_c = '0;
    end else if (b_valid) begin
      ptr_next_c = mod_add_nelem(ptr, b);
    end
  end

  therm_rotate u_rotate (
    .b   (b),
    .ptr (rot_ptr_c),
    .y_c (rot_y_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Y       <= '0;
      Y_valid <= 1'b0;
      ptr     <= '0;
    end else begin
      Y_valid <= b_valid;
      if (b_valid) begin
        Y <= rot_y_c;
      end
      ptr <= ptr_next_c;
    end
  end

endmodule

// File: doc/bin2therm_dwa.md
Name: bin2therm_dwa

Overview:
Binary-to-thermometer decoder: the inverse of the flash-ADC thermometer encoder (therm). Drives the 15 unit elements of the 4-bit segmented sub-DAC, used for residue generation and for ADC self-test loopback. Supports two modes:
- plain thermometer decoding;
- data-weighted averaging (DWA), where a rotating pointer spreads element usage to suppress mismatch error.

Output is registered, with a valid flag.

Parameters:
NBITS, 4, binary code width.
NELEM, 2**NBITS-1 (15), number of unit elements and thermometer width. Derived; not overridable.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
b  input  NBITS  binary code to decode (0..15).
b_valid  input  1  b is sampled on this cycle.
dwa_en  input  1  1 = DWA rotation, 0 = plain thermometer.
Y  output  NELEM  registered element-select word, bit i drives unit element i.
Y_valid  output  1  Y was updated on this cycle.
ptr  output  NBITS  current DWA start pointer (0..14), for debug and verification.

Behaviour:
- Reset, synchronous, active-high: on any rising clk with rst=1, Y=0, Y_valid=0 and ptr=0. Reset has priority over all other inputs, including mid-stream.
- Latency is 1 cycle. When b_valid=1 at edge k, Y and Y_valid=1 appear after edge k.
- When b_valid=0: Y holds its last value, Y_valid=0 and ptr is unchanged.
- Plain mode, dwa_en=0 at the sampling edge:
  - Y[i]=1 iff i<b, so Y=(1<<b)-1.
  - ptr is forced to 0 on every edge where dwa_en=0, whether or not b_valid=1.
- DWA mode, dwa_en=1 with b_valid=1:
  - Y[i]=1 iff ((i-ptr) mod 15) < b, so elements ptr, ptr+1, ..., ptr+b-1 mod 15 are set.
  - ptr_next=(ptr+b) mod 15. Compute the sum in NBITS+1 bits (max 14+15=29) and subtract 15 once if the sum is 15 or more. ptr never reaches 15.
- Boundaries:
  - b=0: Y=0, ptr unchanged.
  - b=15: Y=all ones, ptr unchanged, since (ptr+15) mod 15 = ptr.
  - b equal to the elements remaining from ptr to 14: wraps exactly to ptr=0.
- Mode switch:
  - 1->0: ptr clears to 0 on that edge, and the decode on that edge is plain.
  - 0->1: DWA starts from ptr=0.
- Invariant on every valid output: popcount(Y)=b.
- No other state: no FSM beyond the ptr register and the output registers.

Decomposition:
- Package adc_therm_pkg holds:
  - NBITS and NELEM constants, shared with therm;
  - function mod_add_nelem(ptr, b), returning (ptr+b) mod NELEM.
- Sub-module therm_rotate, purely combinational:
  - inputs: b and ptr;
  - builds the mask (1<<b)-1 and rotates it left by ptr within NELEM bits, with wrap;
  - used for both modes, with ptr=0 in plain mode.
- bin2therm_dwa holds the registers (Y, Y_valid, ptr), mode control and reset.

Test Plan:
1. Reset: rst=1 for 3 cycles with b=9, b_valid=1, dwa_en=1 -> Y=0, Y_valid=0, ptr=0 throughout. Deassert -> first valid output one cycle after the first edge with b_valid=1.
2. Plain sweep: dwa_en=0, b=0..15 back to back with b_valid=1 -> Y=(1<<b)-1 one cycle later; e.g. b=8 gives 15'b000000011111111. ptr stays 0 and popcount(Y)=b.
3. DWA wrap: from ptr=0, dwa_en=1, apply b=5 then b=12:
   - after b=5: Y=15'b000000000011111, ptr=5;
   - after b=12: Y=15'b111111111100011, ptr=2.
4. DWA extremes at ptr=2: b=15 -> Y=15'b111111111111111, ptr=2. Then b=0 -> Y=0, ptr=2. Then b=13 -> elements 2..14 set, Y=15'b111111111111100, ptr=0 (exact wrap).
5. Valid gaps and mode switch:
   - With ptr=7, hold b_valid=0 for 4 cycles while b toggles -> Y held, Y_valid=0, ptr=7.
   - Then dwa_en=0 with b=3, b_valid=1 -> Y=15'b000000000000111, ptr=0.
6. Reset mid-operation: DWA random stream of 200 codes compared against a reference model; assert rst for 1 cycle at ptr=11 -> next cycle Y=0, Y_valid=0, ptr=0. The stream resumes and matches a model restarted from ptr=0.
